spu_issue_scoreboard: RTL and testbench
=======================================

Name: spu_issue_scoreboard

Overview:
Register-hazard scoreboard and issue gate for the pipelined SPU decode stage. It tracks a remaining-latency counter for every register with a write in flight. Each cycle it decides, in order, which of up to ISSUE_WIDTH decoded instructions may issue, checking RAW, WAW and intra-group dependences. It replaces the fixed-distance forwarding/stall logic with a latency-aware, multi-issue, parametrised unit that sits between the ID stage and ID_EX.

Parameters:
ISSUE_WIDTH, 2, instructions presented per cycle (slot 0 oldest)
NUM_REGS, 128, architectural registers
REG_W, 7, register address width (log2 NUM_REGS)
MAX_LAT, 7, largest producer latency in cycles
LAT_W, 3, counter/latency width (clog2(MAX_LAT+1))
FWD_SLACK, 0, remaining-latency value at or below which a source is forwardable (no stall)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
hold  in  1  global pipeline freeze: no issue, counters frozen
slot_valid  in  ISSUE_WIDTH  slot holds a decoded instruction
src_ra / src_rb / src_rc  in  ISSUE_WIDTH*REG_W each  source register addresses, slot s at [s*REG_W +: REG_W]
src_used  in  ISSUE_WIDTH*3  per slot {rc,rb,ra} used flags
rt  in  ISSUE_WIDTH*REG_W  destination register
rt_we  in  ISSUE_WIDTH  slot writes rt
lat  in  ISSUE_WIDTH*LAT_W  producer latency of slot
issue  out  ISSUE_WIDTH  slot issues this cycle (combinational)
stall  out  1  slot_valid[0] & ~issue[0]
busy_vec  out  NUM_REGS  cnt[r] != 0 (combinational from state)

Behaviour:
- State: cnt[r], LAT_W bits, for each r in 0..NUM_REGS-1. All registers are general; no hardwired register.
- Reset (sync): all cnt = 0. issue = 0 and stall = 0 while reset is high, so busy_vec = 0 after the edge. Reset mid-operation discards all pending state.
- Effective latency Leff = clamp(lat, 1, MAX_LAT). lat = 0 is treated as 1.
- Hazards for slot s:
  - RAW: any used source x with cnt[x] > FWD_SLACK.
  - WAW: rt_we and cnt[rt] >= Leff, i.e. the new write would not complete after the pending one.
  - Intra-group, against any older slot k < s in the same group with issue[k] and rt_we[k]:
    - a used source of s equals rt[k] (RAW);
    - rt_we[s] and rt[s] == rt[k] (WAW).
- In-order issue: issue[s] = slot_valid[s] & ~hold & ~reset & no hazard & (s == 0 or issue[s-1]). A blocked slot blocks all younger slots.
- Update, at the rising edge with hold = 0:
  - for each r: if some issued slot has rt_we and rt == r, cnt[r] <= Leff of that slot (load wins over decrement);
  - else if cnt[r] != 0, cnt[r] <= cnt[r] - 1.
  - At most one issued slot targets a given r per cycle (guaranteed by the intra-group WAW rule).
- hold = 1: cnt unchanged, issue = 0, stall = slot_valid[0].
- Sources unused (src_used = 0) never cause hazards. rt_we = 0 never loads a counter.
- Latency: a result produced by a latency-L issue at cycle t is consumable (FWD_SLACK = 0) by an issue at cycle t+L+1 at the earliest; with FWD_SLACK = F, at cycle t+L+1-F.
- No handshake on the output side: ID_EX captures issued slots on the same edge the counters update.

Test Plan:
1. Reset held 2 cycles with slot_valid=11 -> issue=00, stall=0. After release, slot0 writes r5 with lat=3 -> issue[0]=1; next cycle busy_vec[5]=1.
2. RAW (ISSUE_WIDTH=2, FWD_SLACK=0): issue write r5 lat=3 at cycle 0; slot0 reads r5 from cycle 1 -> stall=1 in cycles 1..3, issue[0]=1 in cycle 4, busy_vec[5]=0 in cycle 4.
3. Intra-group: slot0 writes r10, slot1 reads r10 (scoreboard clear) -> issue=01. Slot1 reading r11 instead -> issue=11. Slot0 valid=0 -> issue=00 regardless of slot1.
4. WAW: pending r9 with cnt=4, new write r9 lat=2 -> stall while cnt is 4, 3, 2; issues when cnt=1; cnt[9] reloads to 2.
5. Hold: issue write r7 lat=2, then hold=1 for 5 cycles -> cnt[7] stays at 2 and issue=00 throughout. A reader of r7 issues exactly 2 cycles after hold drops.
6. Clamp/reset: write r3 lat=0 -> cnt[3]=1. Write r4 lat=7, assert reset two cycles later -> busy_vec=0 and a reader of r4 issues immediately after reset deasserts.

Source files
------------

// File: rtl/spu_issue_scoreboard.sv
// Register-hazard scoreboard and in-order issue gate for the SPU decode stage.
// Each register tracks its remaining producer latency; slots issue oldest-first.

module spu_issue_lane #(
  parameter int NUM_REGS  = 128,
  parameter int REG_W     = 7,
  parameter int MAX_LAT   = 7,
  parameter int LAT_W     = 3,
  parameter int FWD_SLACK = 0
) (
  input  logic [NUM_REGS-1:0][LAT_W-1:0] cnt,
  input  logic [REG_W-1:0]               ra,
  input  logic [REG_W-1:0]               rb,
  input  logic [REG_W-1:0]               rc,
  input  logic [2:0]                     used,
  input  logic [REG_W-1:0]               rt,
  input  logic                           rt_we,
  input  logic [LAT_W-1:0]               lat,
  output logic [LAT_W-1:0]               leff,
  output logic                           sb_hazard
);
  logic [LAT_W:0] lat_x;
  logic           raw, waw;

  // lat = 0 still occupies the register for one cycle
  always_comb begin
    lat_x = {1'b0, lat};
    if (lat == '0)                            leff = LAT_W'(1);
    else if (lat_x > (LAT_W+1)'(MAX_LAT))     leff = LAT_W'(MAX_LAT);
    else                                      leff = lat;
  end

  assign raw = (used[0] && (cnt[ra] > LAT_W'(FWD_SLACK))) ||
               (used[1] && (cnt[rb] > LAT_W'(FWD_SLACK))) ||
               (used[2] && (cnt[rc] > LAT_W'(FWD_SLACK)));
  // new write must land strictly after the pending one
  assign waw = rt_we && (cnt[rt] >= leff);
  assign sb_hazard = raw | waw;
endmodule

module spu_issue_scoreboard #(
  parameter int ISSUE_WIDTH = 2,
  parameter int NUM_REGS    = 128,
  parameter int REG_W       = 7,
  parameter int MAX_LAT     = 7,
  parameter int LAT_W       = 3,
  parameter int FWD_SLACK   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic [ISSUE_WIDTH-1:0]         slot_valid,
  input  logic [ISSUE_WIDTH*REG_W-1:0]   src_ra,
  input  logic [ISSUE_WIDTH*REG_W-1:0]   src_rb,
  input  logic [ISSUE_WIDTH*REG_W-1:0]   src_rc,
  input  logic [ISSUE_WIDTH*3-1:0]       src_used,
  input  logic [ISSUE_WIDTH*REG_W-1:0]   rt,
  input  logic [ISSUE_WIDTH-1:0]         rt_we,
  input  logic [ISSUE_WIDTH*LAT_W-1:0]   lat,
  output logic [ISSUE_WIDTH-1:0]         issue,
  output logic                           stall,
  output logic [NUM_REGS-1:0]            busy_vec
);
  typedef struct packed {
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [2:0]       used;
    logic [REG_W-1:0] rt;
    logic             rt_we;
  } slot_req_t;

  logic [NUM_REGS-1:0][LAT_W-1:0]    cnt, cnt_nxt;
  slot_req_t [ISSUE_WIDTH-1:0]       req;
  logic [ISSUE_WIDTH-1:0][LAT_W-1:0] leff;
  logic [ISSUE_WIDTH-1:0]            sb_hazard;
  logic [ISSUE_WIDTH-1:0]            iss;
  logic                              blocked, hz;

  for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_lane
    assign req[s] = '{ra:    src_ra[s*REG_W +: REG_W],
                      rb:    src_rb[s*REG_W +: REG_W],
                      rc:    src_rc[s*REG_W +: REG_W],
                      used:  src_used[s*3 +: 3],
                      rt:    rt[s*REG_W +: REG_W],
                      rt_we: rt_we[s]};

    spu_issue_lane #(
      .NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_LAT(MAX_LAT),
      .LAT_W(LAT_W), .FWD_SLACK(FWD_SLACK)
    ) u_lane (
      .cnt       (cnt),
      .ra        (req[s].ra),
      .rb        (req[s].rb),
      .rc        (req[s].rc),
      .used      (req[s].used),
      .rt        (req[s].rt),
      .rt_we     (req[s].rt_we),
      .lat       (lat[s*LAT_W +: LAT_W]),
      .leff      (leff[s]),
      .sb_hazard (sb_hazard[s])
    );
  end

  // In-order gate: intra-group deps only count against older slots that issue
  always_comb begin
    iss     = '0;
    hz      = 1'b0;
    blocked = reset | hold;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      hz = sb_hazard[s];
      for (int k = 0; k < s; k++) begin
        if (iss[k] && req[k].rt_we) begin
          if (req[s].used[0] && (req[s].ra == req[k].rt)) hz = 1'b1;
          if (req[s].used[1] && (req[s].rb == req[k].rt)) hz = 1'b1;
          if (req[s].used[2] && (req[s].rc == req[k].rt)) hz = 1'b1;
          if (req[s].rt_we   && (req[s].rt == req[k].rt)) hz = 1'b1;
        end
      end
      iss[s]  = slot_valid[s] & ~blocked & ~hz;
      blocked = blocked | ~iss[s];
    end
  end

  assign issue = iss;
  assign stall = slot_valid[0] & ~iss[0] & ~reset;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
    // a fresh load overrides the decrement
    for (int s = 0; s < ISSUE_WIDTH; s++)
      if (iss[s] && req[s].rt_we) cnt_nxt[req[s].rt] = leff[s];
  end

  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (!hold) cnt <= cnt_nxt;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
    assign busy_vec[r] = |cnt[r];
  end
endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed scenarios plus a randomized run against a completion-time model.
module tb_spu_issue_scoreboard;
  localparam int IW = 2, NR = 128, RW = 7, ML = 7, LW = 3, FS = 0;

  logic              clk = 1'b0;
  logic              reset, hold;
  logic [IW-1:0]     slot_valid, rt_we, issue;
  logic [IW*RW-1:0]  src_ra, src_rb, src_rc, rt;
  logic [IW*3-1:0]   src_used;
  logic [IW*LW-1:0]  lat;
  logic              stall;
  logic [NR-1:0]     busy_vec;

  int tests = 0, fails = 0;
  int done_at [NR];
  int now_eff;

  spu_issue_scoreboard #(
    .ISSUE_WIDTH(IW), .NUM_REGS(NR), .REG_W(RW), .MAX_LAT(ML), .LAT_W(LW), .FWD_SLACK(FS)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .slot_valid(slot_valid),
    .src_ra(src_ra), .src_rb(src_rb), .src_rc(src_rc), .src_used(src_used),
    .rt(rt), .rt_we(rt_we), .lat(lat),
    .issue(issue), .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_slots();
    slot_valid = '0; src_ra = '0; src_rb = '0; src_rc = '0;
    src_used = '0; rt = '0; rt_we = '0; lat = '0;
  endtask

  task automatic set_slot(input int s, input bit v, input int ra, input int rb, input int rc,
                          input bit [2:0] used, input int d, input bit we, input int l);
    slot_valid[s]        = v;
    src_ra[s*RW +: RW]   = RW'(ra);
    src_rb[s*RW +: RW]   = RW'(rb);
    src_rc[s*RW +: RW]   = RW'(rc);
    src_used[s*3 +: 3]   = used;
    rt[s*RW +: RW]       = RW'(d);
    rt_we[s]             = we;
    lat[s*LW +: LW]      = LW'(l);
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0; clear_slots();
    tick(); tick();
    reset = 1'b0;
  endtask

  function automatic int rem_of(input int r);
    return (done_at[r] > now_eff) ? done_at[r] - now_eff : 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; clear_slots();
    set_slot(0, 1, 0, 0, 0, 3'b000, 1, 1, 2);
    set_slot(1, 1, 0, 0, 0, 3'b000, 2, 1, 2);
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if (issue !== 2'b00) begin fails++; $display("FAIL reset_issue c=%0d got %b want 00", c, issue); end
      tests++; if (stall !== 1'b0)  begin fails++; $display("FAIL reset_stall c=%0d got %b want 0", c, stall); end
      tick();
    end
    tests++; if (busy_vec !== '0) begin fails++; $display("FAIL reset_busy got %h want 0", busy_vec); end
    reset = 1'b0; clear_slots();
    set_slot(0, 1, 0, 0, 0, 3'b000, 5, 1, 3);
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL first_issue got %b want 01", issue); end
    tick(); clear_slots(); #1;
    tests++; if (busy_vec[5] !== 1'b1) begin fails++; $display("FAIL first_busy5 got %b want 1", busy_vec[5]); end
  endtask

  task automatic test_raw();
    do_reset();
    set_slot(0, 1, 0, 0, 0, 3'b000, 5, 1, 3);
    tick(); clear_slots();
    set_slot(0, 1, 5, 0, 0, 3'b001, 0, 0, 1);
    for (int c = 1; c <= 3; c++) begin
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL raw_stall c=%0d got %b want 1", c, stall); end
      tick();
    end
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL raw_issue got %b want 01", issue); end
    tests++; if (busy_vec[5] !== 1'b0) begin fails++; $display("FAIL raw_busy5 got %b want 0", busy_vec[5]); end
    tick(); clear_slots();
  endtask

  task automatic test_intra_group();
    do_reset();
    set_slot(0, 1, 0, 0, 0, 3'b000, 10, 1, 2);
    set_slot(1, 1, 0, 10, 0, 3'b010, 20, 1, 1);
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL intra_raw got %b want 01", issue); end
    set_slot(1, 1, 0, 11, 0, 3'b010, 20, 1, 1);
    #1;
    tests++; if (issue !== 2'b11) begin fails++; $display("FAIL intra_indep got %b want 11", issue); end
    set_slot(1, 1, 0, 0, 0, 3'b000, 10, 1, 1);
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL intra_waw got %b want 01", issue); end
    set_slot(1, 1, 0, 11, 0, 3'b010, 20, 1, 1);
    slot_valid[0] = 1'b0;
    #1;
    tests++; if (issue !== 2'b00) begin fails++; $display("FAIL intra_order got %b want 00", issue); end
    clear_slots(); tick();
  endtask

  task automatic test_waw();
    do_reset();
    set_slot(0, 1, 0, 0, 0, 3'b000, 9, 1, 4);
    tick(); clear_slots();
    set_slot(0, 1, 0, 0, 0, 3'b000, 9, 1, 2);
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_stall c=%0d got %b want 1", c, stall); end
      tick();
    end
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL waw_issue got %b want 01", issue); end
    tick(); clear_slots();
    set_slot(0, 1, 0, 0, 9, 3'b100, 0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_reload_stall c=%0d got %b want 1", c, stall); end
      tick();
    end
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL waw_reload_issue got %b want 01", issue); end
    tick(); clear_slots();
  endtask

  task automatic test_hold();
    do_reset();
    set_slot(0, 1, 0, 0, 0, 3'b000, 7, 1, 2);
    tick(); clear_slots();
    set_slot(0, 1, 7, 0, 0, 3'b001, 0, 0, 1);
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (issue !== 2'b00) begin fails++; $display("FAIL hold_issue c=%0d got %b want 00", c, issue); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hold_stall c=%0d got %b want 1", c, stall); end
      tests++; if (busy_vec[7] !== 1'b1) begin fails++; $display("FAIL hold_busy7 c=%0d got %b want 1", c, busy_vec[7]); end
      tick();
    end
    hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hold_after_stall c=%0d got %b want 1", c, stall); end
      tick();
    end
    #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL hold_after_issue got %b want 01", issue); end
    tick(); clear_slots();
  endtask

  task automatic test_clamp_reset();
    do_reset();
    set_slot(0, 1, 0, 0, 0, 3'b000, 3, 1, 0);
    tick(); clear_slots();
    set_slot(0, 1, 3, 0, 0, 3'b001, 0, 0, 1);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL clamp_stall got %b want 1", stall); end
    tick(); #1;
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL clamp_issue got %b want 01", issue); end
    tick(); clear_slots();
    set_slot(0, 1, 0, 0, 0, 3'b000, 4, 1, 7);
    tick(); clear_slots(); tick();
    reset = 1'b1;
    set_slot(0, 1, 4, 0, 0, 3'b001, 0, 0, 1);
    #1;
    tests++; if (issue !== 2'b00) begin fails++; $display("FAIL midreset_issue got %b want 00", issue); end
    tick(); reset = 1'b0; #1;
    tests++; if (busy_vec !== '0) begin fails++; $display("FAIL midreset_busy got %h want 0", busy_vec); end
    tests++; if (issue !== 2'b01) begin fails++; $display("FAIL midreset_reader got %b want 01", issue); end
    tick(); clear_slots();
  endtask

  task automatic test_random();
    int v[IW], a[IW], b[IW], c[IW], d[IW], w[IW], l[IW], le[IW];
    bit [2:0] u[IW];
    bit [IW-1:0] exp_iss;
    bit [NR-1:0] exp_busy;
    bit exp_stall, blk, hz;
    do_reset();
    for (int r = 0; r < NR; r++) done_at[r] = 0;
    now_eff = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      for (int s = 0; s < IW; s++) begin
        v[s] = ($urandom_range(0, 7) != 0);
        a[s] = $urandom_range(0, 7); b[s] = $urandom_range(0, 7); c[s] = $urandom_range(0, 7);
        u[s] = 3'($urandom_range(0, 7));
        d[s] = $urandom_range(0, 7);
        w[s] = ($urandom_range(0, 3) != 0);
        l[s] = $urandom_range(0, 7);
        le[s] = (l[s] == 0) ? 1 : ((l[s] > ML) ? ML : l[s]);
        set_slot(s, v[s] != 0, a[s], b[s], c[s], u[s], d[s], w[s] != 0, l[s]);
      end
      exp_iss = '0;
      blk = reset | hold;
      for (int s = 0; s < IW; s++) begin
        hz = 1'b0;
        if (u[s][0] && rem_of(a[s]) > FS) hz = 1'b1;
        if (u[s][1] && rem_of(b[s]) > FS) hz = 1'b1;
        if (u[s][2] && rem_of(c[s]) > FS) hz = 1'b1;
        if (w[s] != 0 && rem_of(d[s]) >= le[s]) hz = 1'b1;
        for (int k = 0; k < s; k++) begin
          if (exp_iss[k] && w[k] != 0) begin
            if ((u[s][0] && a[s] == d[k]) || (u[s][1] && b[s] == d[k]) ||
                (u[s][2] && c[s] == d[k]) || (w[s] != 0 && d[s] == d[k])) hz = 1'b1;
          end
        end
        exp_iss[s] = (v[s] != 0) && !blk && !hz;
        if (!exp_iss[s]) blk = 1'b1;
      end
      exp_stall = (v[0] != 0) && !exp_iss[0] && !reset;
      for (int r = 0; r < NR; r++) exp_busy[r] = (rem_of(r) > 0);
      #1;
      tests++; if (issue !== exp_iss) begin fails++; $display("FAIL rnd_issue cyc=%0d got %b want %b", cyc, issue, exp_iss); end
      tests++; if (stall !== exp_stall) begin fails++; $display("FAIL rnd_stall cyc=%0d got %b want %b", cyc, stall, exp_stall); end
      tests++; if (busy_vec !== exp_busy) begin fails++; $display("FAIL rnd_busy cyc=%0d got %h want %h", cyc, busy_vec, exp_busy); end
      tick();
      if (reset) begin
        for (int r = 0; r < NR; r++) done_at[r] = 0;
        now_eff = 0;
      end else if (!hold) begin
        for (int s = 0; s < IW; s++)
          if (exp_iss[s] && w[s] != 0) done_at[d[s]] = now_eff + le[s] + 1;
        now_eff++;
      end
    end
    reset = 1'b0; hold = 1'b0; clear_slots(); tick();
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; clear_slots();
    test_reset();
    test_raw();
    test_intra_group();
    test_waw();
    test_hold();
    test_clamp_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
